// File: rtl/timer_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : timer_arbiter_if
// Purpose  : Bundle of request / grant / status signals shared between the
//            requesting protocol FSMs and the shared interval timer.
// Ports    : tick     - count enable strobe, driven by the requester side
//            req      - level request per requester
//            req_len  - packed interval lengths, slice i = [i*NUM_BITS +: NUM_BITS]
//            grant    - one-hot owner of the counter (zero when unowned)
//            done     - one-cycle pulse to the owner at end of interval
//            busy     - counter currently owned
//            count    - current interval count
// Modports : master = requester side, slave = timer_arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface timer_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_BITS = 16
);

  logic                         tick;
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*NUM_BITS-1:0]  req_len;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           done;
  logic                         busy;
  logic [NUM_BITS-1:0]          count;

  modport master (
    output tick,
    output req,
    output req_len,
    input  grant,
    input  done,
    input  busy,
    input  count
  );

  modport slave (
    input  tick,
    input  req,
    input  req_len,
    output grant,
    output done,
    output busy,
    output count
  );

endinterface
`default_nettype wire

// File: rtl/timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : timer_arbiter
// Purpose  : Shares one programmable interval counter among NUM_REQ
//            requesters with round-robin arbitration. The winner's length is
//            latched at grant, tick-qualified cycles are counted to the end
//            of the interval, then done is pulsed to the owner and the
//            counter is released.
// Ports    : clk    - clock
//            n_rst  - asynchronous, active-low reset
//            bus    - timer_arbiter_if.slave (tick, req, req_len in;
//                     grant, done, busy, count out)
// Revision : 1.0 - initial release
// ============================================================================
module timer_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_BITS = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  timer_arbiter_if.slave     bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_busy;
  logic [NUM_BITS-1:0]  r_count;
  logic [NUM_BITS-1:0]  r_len;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [PTR_W-1:0]     r_owner;

  // --------------------------------------------------------------------------
  // Next-state values
  // --------------------------------------------------------------------------
  state_t               w_state_nxt;
  logic [NUM_REQ-1:0]   w_grant_nxt;
  logic [NUM_REQ-1:0]   w_done_nxt;
  logic                 w_busy_nxt;
  logic [NUM_BITS-1:0]  w_count_nxt;
  logic [NUM_BITS-1:0]  w_len_nxt;
  logic [PTR_W-1:0]     w_rr_ptr_nxt;
  logic [PTR_W-1:0]     w_owner_nxt;

  // --------------------------------------------------------------------------
  // Arbitration helpers
  // --------------------------------------------------------------------------
  logic                 w_any_req;
  logic [PTR_W:0]       w_sum;
  logic [PTR_W-1:0]     w_win;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic [PTR_W:0]       w_inc;
  logic [PTR_W-1:0]     w_win_plus1;
  logic [NUM_BITS-1:0]  w_last;
  logic                 w_owner_req;

  assign w_any_req   = |bus.req;
  assign w_owner_req = bus.req[r_owner];

  // Terminal count value: a zero length behaves as a length of one.
  assign w_last = (r_len == '0) ? '0 : (r_len - NUM_BITS'(1));

  // Round-robin search. Candidates are visited from the farthest to the
  // nearest offset from r_rr_ptr so that the last hit, which is the one kept,
  // is the first set bit in search order. The extra sum bit keeps the
  // modulo reduction correct for non-power-of-two NUM_REQ.
  always_comb begin
    w_sum = '0;
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      end
      if (bus.req[w_sum[PTR_W-1:0]]) begin
        w_win = w_sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
  end

  // Pointer moves one past the winner, wrapping at NUM_REQ.
  always_comb begin
    w_inc = {1'b0, w_win} + (PTR_W+1)'(1);
    if (w_inc == (PTR_W+1)'(NUM_REQ)) begin
      w_win_plus1 = '0;
    end else begin
      w_win_plus1 = w_inc[PTR_W-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state and registered-output values
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_done_nxt   = '0;
    w_busy_nxt   = r_busy;
    w_count_nxt  = r_count;
    w_len_nxt    = r_len;
    w_rr_ptr_nxt = r_rr_ptr;
    w_owner_nxt  = r_owner;

    case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_count_nxt = '0;
        if (w_any_req) begin
          w_state_nxt  = S_RUN;
          w_grant_nxt  = w_win_oh;
          w_busy_nxt   = 1'b1;
          w_len_nxt    = bus.req_len[w_win*NUM_BITS +: NUM_BITS];
          w_rr_ptr_nxt = w_win_plus1;
          w_owner_nxt  = w_win;
        end
      end

      S_RUN: begin
        // Withdrawal is checked first so it beats a coincident terminal count.
        if (!w_owner_req) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_count_nxt = '0;
        end else if (bus.tick) begin
          if (r_count == w_last) begin
            w_state_nxt = S_DONE;
            w_grant_nxt = '0;
            // The current grant vector is already one-hot on the owner.
            w_done_nxt  = r_grant;
          end else begin
            w_count_nxt = r_count + NUM_BITS'(1);
          end
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_count_nxt = '0;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_count_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_count  <= '0;
      r_len    <= '0;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
      r_count  <= w_count_nxt;
      r_len    <= w_len_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_owner  <= w_owner_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.grant = r_grant;
  assign bus.done  = r_done;
  assign bus.busy  = r_busy;
  assign bus.count = r_count;

endmodule
`default_nettype wire
